// File: rtl/pc_gen.sv
// Fetch program counter with jr/j/branch redirect and optional MIPS delay slot.
// Build option: define PC_GEN_DELAY_SLOT_EN to enable the architectural delay slot.
module pc_gen #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              is_br,
    input  logic              br_cond,
    input  logic              is_jump,
    input  logic              is_jr,
    input  logic [15:0]       br_off,
    input  logic [25:0]       j_index,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              in_slot,
    output logic              misalign
);

    localparam logic [ADDR_W-1:0] RESET_VAL = RESET_PC[ADDR_W-1:0];

    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;
    logic [ADDR_W-1:0] target;
    logic              jr_bad;
    logic              redirect;
    logic [ADDR_W-1:0] pc_nxt;
    logic              mis_nxt;

    assign pc_plus4  = pc + ADDR_W'(4);
    assign br_target = pc_plus4 + {{(ADDR_W-18){br_off[15]}}, br_off, 2'b00};
    assign j_target  = {pc_plus4[ADDR_W-1:28], j_index, 2'b00};

    // jr outranks everything, so a misaligned jr suppresses lower-priority requests too
    always_comb begin
        jr_bad   = is_jr && (jr_target[1:0] != 2'b00);
        target   = br_target;
        if (is_jr)
            target = jr_target;
        else if (is_jump)
            target = j_target;
        redirect = (is_jr || is_jump || (is_br && br_cond)) && !jr_bad;
    end

`ifdef PC_GEN_DELAY_SLOT_EN
    typedef enum logic {IDLE, SLOT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] tgt, tgt_nxt;
    logic              slot_nxt;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        tgt_nxt   = tgt;
        slot_nxt  = in_slot;
        mis_nxt   = 1'b0;
        if (!stall) begin
            unique case (state)
                IDLE: begin
                    pc_nxt = pc_plus4;
                    if (redirect) begin
                        state_nxt = SLOT;
                        tgt_nxt   = target;
                        slot_nxt  = 1'b1;
                    end else begin
                        mis_nxt = jr_bad;
                    end
                end
                SLOT: begin
                    state_nxt = IDLE;
                    pc_nxt    = tgt;
                    slot_nxt  = 1'b0;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_VAL;
            tgt      <= '0;
            in_slot  <= 1'b0;
            misalign <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            tgt      <= tgt_nxt;
            in_slot  <= slot_nxt;
            misalign <= mis_nxt;
        end
    end
`else
    assign in_slot = 1'b0;

    always_comb begin
        pc_nxt  = pc;
        mis_nxt = 1'b0;
        if (!stall) begin
            pc_nxt  = redirect ? target : pc_plus4;
            mis_nxt = jr_bad;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_VAL;
            misalign <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            misalign <= mis_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus pushes reference-model predictions, a negedge monitor checks them.
module tb_pc_gen;

`ifdef PC_GEN_DELAY_SLOT_EN
    localparam bit SLOT_EN = 1'b1;
`else
    localparam bit SLOT_EN = 1'b0;
`endif
    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        is_br = 1'b0;
    logic        br_cond = 1'b0;
    logic        is_jump = 1'b0;
    logic        is_jr = 1'b0;
    logic [15:0] br_off = '0;
    logic [25:0] j_index = '0;
    logic [31:0] jr_target = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        in_slot;
    logic        misalign;

    pc_gen #(
        .ADDR_W  (32),
        .RESET_PC(RST_PC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .is_br    (is_br),
        .br_cond  (br_cond),
        .is_jump  (is_jump),
        .is_jr    (is_jr),
        .br_off   (br_off),
        .j_index  (j_index),
        .jr_target(jr_target),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .in_slot  (in_slot),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        slot;
        logic        mis;
        int          step;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    // reference model: architectural state plus the inputs seen at the previous edge
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_tgt = '0;
    logic        m_pend = 1'b0;
    logic        m_slot = 1'b0;
    logic        m_mis = 1'b0;
    logic        p_rst = 1'b1, p_stall = 1'b0, p_br = 1'b0, p_cond = 1'b0, p_jmp = 1'b0, p_jr = 1'b0;
    logic [15:0] p_off = '0;
    logic [25:0] p_idx = '0;
    logic [31:0] p_jrt = '0;

    task automatic model_reset();
        m_pc   = RST_PC;
        m_tgt  = '0;
        m_pend = 1'b0;
        m_slot = 1'b0;
        m_mis  = 1'b0;
    endtask

    task automatic advance();
        logic [31:0] t;
        bit          req;
        bit          bad;
        m_mis = 1'b0;
        if (p_rst || p_stall) return;
        if (m_pend) begin
            m_pc   = m_tgt;
            m_pend = 1'b0;
            m_slot = 1'b0;
            return;
        end
        req = 1'b1;
        bad = 1'b0;
        t   = '0;
        if (p_jr) begin
            t   = p_jrt;
            bad = (t % 4) != 0;
        end else if (p_jmp) begin
            t = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'b0, p_idx} * 32'd4);
        end else if (p_br && p_cond) begin
            t = m_pc + 32'd4 + 32'(int'($signed(p_off)) * 4);
        end else begin
            req = 1'b0;
        end
        if (req && !bad) begin
            if (SLOT_EN) begin
                m_pc   = m_pc + 32'd4;
                m_tgt  = t;
                m_pend = 1'b1;
                m_slot = 1'b1;
            end else begin
                m_pc = t;
            end
        end else begin
            m_pc  = m_pc + 32'd4;
            m_mis = bad;
        end
    endtask

    task automatic step(input logic s, input logic br, input logic cond, input logic jmp,
                        input logic jr, input logic [15:0] off, input logic [25:0] idx,
                        input logic [31:0] jrt, input logic rst);
        exp_t e;
        @(posedge clk);
        #2;
        advance();
        reset = rst; stall = s; is_br = br; br_cond = cond; is_jump = jmp; is_jr = jr;
        br_off = off; j_index = idx; jr_target = jrt;
        p_rst = rst; p_stall = s; p_br = br; p_cond = cond; p_jmp = jmp; p_jr = jr;
        p_off = off; p_idx = idx; p_jrt = jrt;
        if (rst) model_reset();
        step_no++;
        e.pc   = m_pc;
        e.slot = m_slot;
        e.mis  = m_mis;
        e.step = step_no;
        sb.push_back(e);
    endtask

    task automatic nop();                        step(0, 0, 0, 0, 0, '0, '0, '0, 0); endtask
    task automatic rst_step();                   step(0, 0, 0, 0, 0, '0, '0, '0, 1); endtask
    task automatic stl();                        step(1, 1, 1, 1, 1, 16'h0010, 26'h1, 32'h5000, 0); endtask
    task automatic br(input logic [15:0] off);   step(0, 1, 1, 0, 0, off, '0, '0, 0); endtask
    task automatic jmp(input logic [25:0] idx);  step(0, 0, 0, 1, 0, '0, idx, '0, 0); endtask
    task automatic jr(input logic [31:0] t);     step(0, 0, 0, 0, 1, '0, '0, t, 0); endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int stp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=0x%08h required=0x%08h", name, stp, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pc", pc, e.pc, e.step);
                chk("pc_plus4", pc_plus4, e.pc + 32'd4, e.step);
                chk("in_slot", {31'b0, in_slot}, {31'b0, e.slot}, e.step);
                chk("misalign", {31'b0, misalign}, {31'b0, e.mis}, e.step);
            end
        end
    end

    initial begin : stimulus
        rst_step();
        rst_step();
        for (int unsigned i = 0; i < 5; i++) nop();
        br(16'hFFFC);
        for (int unsigned i = 0; i < 3; i++) nop();
        jr(32'h0000_3020);
        nop();
        nop();
        step(0, 0, 0, 1, 1, '0, 26'h0000100, 32'h0000_4000, 0);
        nop();
        nop();
        step(0, 1, 1, 1, 0, 16'h0004, 26'h0000200, '0, 0);
        nop();
        nop();
        rst_step();
        nop();
        jr(32'h0000_3006);
        nop();
        nop();
        br(16'h0008);
        stl();
        stl();
        nop();
        nop();
        jmp(26'h0000300);
        rst_step();
        nop();
        nop();
        nop();
        br(16'h0000);
        step(0, 1, 0, 0, 0, 16'h0040, '0, '0, 0);
        nop();
        jr(32'hFFFF_FFF8);
        for (int unsigned i = 0; i < 4; i++) nop();
        jr(32'h7FFF_FFFC);
        nop();
        jmp(26'h3FFFFFF);
        nop();
        nop();
        stl();
        jr(32'h0000_5001);
        stl();
        nop();

        for (int unsigned i = 0; i < 400; i++) begin
            logic        s, b, c, j, r, rs;
            logic [31:0] t;
            s  = ($urandom_range(0, 4) == 0);
            b  = ($urandom_range(0, 3) == 0);
            c  = $urandom_range(0, 1) != 0;
            j  = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 59) == 0);
            t  = $urandom;
            if ($urandom_range(0, 1) != 0) t[1:0] = 2'b00;
            step(s, b, c, j, r, 16'($urandom), 26'($urandom), t, rs);
        end
        nop();

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
